calc_bank: RTL and testbench
============================

# calc_bank

Parametrised successor to the board calculator. It holds a bank of `NACC` independent signed accumulators of `WIDTH` bits, selected by a switch-driven index. It synchronises and edge-detects the execute and clear buttons, so one press performs exactly one operation. Results pass through a small FSM pipeline that also produces sticky overflow flags. The block sits between the board I/O (buttons, switches, LEDs) and replaces the single-accumulator datapath with a self-contained ALU.

## Interface
- `WIDTH`, 16: operand/accumulator width in bits; ≥ 4.
- `NACC`, 4: number of accumulators; power of two, ≥ 2.
- `SYNC_STAGES`, 2: synchroniser depth for `btnd`/`btnu`; ≥ 2.

Ports:
- `clk` in 1: clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high; clears everything.
- `btnc`, `btnl`, `btnr` in 1 each: level op select, `op = {btnc,btnl,btnr}`.
- `btnd` in 1: execute request; asynchronous, synchronised internally.
- `btnu` in 1: clear the selected accumulator; asynchronous, synchronised internally.
- `acc_sel` in `$clog2(NACC)`: accumulator index.
- `sw` in `WIDTH`: operand 2, signed.
- `led` out `WIDTH`: `bank[acc_sel]`.
- `ovf` out 1: sticky overflow flag of `bank[acc_sel]`.
- `zero` out 1: `led == 0`.
- `busy` out 1: high while state is EXEC or WRITE.

## Operation
- **Synchronisers.** `btnd` and `btnu` each pass through `SYNC_STAGES` flops, followed by a `prev` flop.
  - Edge pulse = `sync_out & ~prev`.
  - The pulse is high for one cycle per rising edge; holding a button never repeats.
- **FSM.** States are IDLE, EXEC, WRITE.
  - **IDLE, `btnu` edge:** clear `bank[acc_sel]` and `ovf_flag[acc_sel]`; stay in IDLE.
  - **IDLE, `btnd` edge without `btnu` edge:** latch `op_q`, `sel_q = acc_sel`, `a_q = bank[acc_sel]`, `b_q = sw`; go to EXEC.
  - **IDLE, both edges in the same cycle:** the clear wins and the execute is dropped.
  - **EXEC:** register `res_q` and `ovf_q` computed from `a_q`, `b_q`, `op_q`; go to WRITE.
  - **WRITE:** `bank[sel_q] <= res_q`; `ovf_flag[sel_q] <= ovf_flag[sel_q] | ovf_q`; go to IDLE.
  - Edge pulses arriving in EXEC or WRITE are discarded, not queued.
- **Ops.** `a` = accumulator, `b` = `sw`, both two's complement; shift amount `sh = b[$clog2(WIDTH)-1:0]`.
  - 000 ADD: `a+b`; `ovf` = signed overflow.
  - 001 SUB: `a-b`; `ovf` = signed overflow.
  - 010 AND, 011 OR, 100 XOR: bitwise; `ovf` = 0.
  - 101 SLL: `a << sh`; `ovf` = 0.
  - 110 SRA: `a >>> sh`; `ovf` = 0.
  - 111 MUL: low `WIDTH` bits of the 2·`WIDTH` signed product; `ovf` = 1 if the product is not equal to the sign-extension of its low half.
- **Operand capture.** `acc_sel` and `sw` only matter at the capture cycle; changing them during EXEC/WRITE does not affect the result. `led`, `ovf` and `zero` follow `acc_sel` combinationally at all times.
- **Overflow.** `ovf_flag` is sticky. Only a `btnu` clear of that accumulator, or `reset`, clears it.

## Timing
- **Reset.** While `reset` is high at a clock edge:
  - all bank entries, overflow flags, synchroniser and `prev` flops clear to 0;
  - state goes to IDLE.
  - After reset: `led` = 0, `ovf` = 0, `zero` = 1, `busy` = 0.
  - Reset asserted in EXEC or WRITE aborts the operation with no bank write.
  - A button held high through reset deassertion is seen as a new press.
- **Execute latency** (`SYNC_STAGES` = 2, `btnd` first sampled high at edge k):
  - edge pulse high after edge k+1;
  - capture and EXEC at edge k+2;
  - WRITE at edge k+3;
  - bank updated and IDLE at edge k+4;
  - `busy` high between edges k+2 and k+4.
  - In general, latency = `SYNC_STAGES` + 2 edges.
- **Clear latency.** `bank[acc_sel]` = 0 after edge `SYNC_STAGES` (k+2 for the default), provided the block is IDLE.
- **Throughput.** At most one operation per 3 cycles. A `btnd` released and re-pressed inside a busy window is lost.

## Test plan
- **Reset:** reset for 2 cycles -> `led` = 0x0000, `zero` = 1, `ovf` = 0, `busy` = 0 for every `acc_sel`.
- **Arithmetic chain:** `acc_sel` = 0, op 000 with `sw` = 5, then op 001 with `sw` = 7 -> `led` = 0xFFFE, `zero` = 0, `ovf` = 0. Each result lands exactly 4 edges after the press.
- **Sticky overflow and multiply:**
  - ADD `sw` = 0x7FFF, then ADD `sw` = 0x0001 -> `led` = 0x8000, `ovf` = 1.
  - ADD `sw` = 0 -> `ovf` stays 1.
  - `btnu` -> `led` = 0, `ovf` = 0.
  - MUL: load 0x0100, then MUL `sw` = 0x0100 -> `led` = 0x0000, `ovf` = 1.
- **Bank independence:** load 3 into `acc_sel` = 1 and 9 into `acc_sel` = 2 (ADD from 0). SRA `acc_sel` = 2 with `sw` = 1 -> `acc_sel` = 2 shows 4, `acc_sel` = 1 shows 3, and 0 and 3 show 0.
- **Button rules:**
  - `btnd` held high for 20 cycles with ADD `sw` = 1 -> exactly one increment.
  - `btnu` and `btnd` rising in the same cycle -> accumulator = 0 and no operation; `busy` never asserts.
  - Second `btnd` edge during `busy` -> ignored.
- **Reset mid-operation:** press ADD `sw` = 10, assert reset during EXEC -> no write occurs; `led` = 0 and state is IDLE after the reset edge.

Source files
------------

// File: rtl/calc_bank.sv
// calc_bank: a bank of NACC signed WIDTH-bit accumulators driven by board buttons.
//
// Ports:
//   clk                    clock; all state changes on the rising edge
//   reset                  synchronous, active-high; clears all state
//   btnc, btnl, btnr       level op select, op = {btnc, btnl, btnr}
//   btnd                   execute request (asynchronous, synchronised here)
//   btnu                   clear the selected accumulator (asynchronous, synchronised here)
//   acc_sel                accumulator index
//   sw                     operand b, signed
//   led                    bank[acc_sel]
//   ovf                    sticky overflow flag of bank[acc_sel]
//   zero                   led == 0
//   busy                   high while an operation is in EXEC or WRITE
module calc_bank #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned NACC        = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     btnc,
    input  logic                     btnl,
    input  logic                     btnr,
    input  logic                     btnd,
    input  logic                     btnu,
    input  logic [$clog2(NACC)-1:0]  acc_sel,
    input  logic [WIDTH-1:0]         sw,
    output logic [WIDTH-1:0]         led,
    output logic                     ovf,
    output logic                     zero,
    output logic                     busy
);

    localparam int unsigned ShW  = $clog2(WIDTH);
    localparam int unsigned SelW = $clog2(NACC);

    typedef enum logic [1:0] {StIdle, StExec, StWrite} state_e;
    typedef enum logic [2:0] {
        OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSll, OpSra, OpMul
    } op_e;

    state_e                 state_q;
    logic                   busy_q;
    logic [WIDTH-1:0]       bank_q [NACC];
    logic [NACC-1:0]        ovf_flag_q;

    logic [SYNC_STAGES-1:0] btnd_sync_q;
    logic [SYNC_STAGES-1:0] btnu_sync_q;
    logic                   btnd_prev_q;
    logic                   btnu_prev_q;
    logic                   btnd_pulse;
    logic                   btnu_pulse;

    op_e                    op_q;
    logic [SelW-1:0]        sel_q;
    logic [WIDTH-1:0]       a_q;
    logic [WIDTH-1:0]       b_q;
    logic [WIDTH-1:0]       res_q;
    logic                   ovf_q;

    // Rising-edge pulses; the prev flop sits after the last synchroniser stage.
    assign btnd_pulse = btnd_sync_q[SYNC_STAGES-1] & ~btnd_prev_q;
    assign btnu_pulse = btnu_sync_q[SYNC_STAGES-1] & ~btnu_prev_q;

    // ALU on the captured operands
    logic [WIDTH-1:0]         sum;
    logic [WIDTH-1:0]         diff;
    logic signed [2*WIDTH-1:0] a_ext;
    logic signed [2*WIDTH-1:0] b_ext;
    logic signed [2*WIDTH-1:0] prod;
    logic [ShW-1:0]           sh;
    logic [WIDTH-1:0]         alu_res;
    logic                     alu_ovf;

    always_comb begin
        sum     = a_q + b_q;
        diff    = a_q - b_q;
        a_ext   = {{WIDTH{a_q[WIDTH-1]}}, a_q};
        b_ext   = {{WIDTH{b_q[WIDTH-1]}}, b_q};
        prod    = a_ext * b_ext;
        sh      = b_q[ShW-1:0];
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op_q)
            OpAdd: begin
                alu_res = sum;
                alu_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OpSub: begin
                alu_res = diff;
                alu_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            OpAnd: alu_res = a_q & b_q;
            OpOr:  alu_res = a_q | b_q;
            OpXor: alu_res = a_q ^ b_q;
            OpSll: alu_res = a_q << sh;
            OpSra: alu_res = $signed(a_q) >>> sh;
            OpMul: begin
                alu_res = prod[WIDTH-1:0];
                // Overflow when the high half is not just the sign of the low half
                alu_ovf = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
            end
            default: begin
                alu_res = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            for (int i = 0; i < int'(NACC); i++) begin
                bank_q[i] <= '0;
            end
            ovf_flag_q  <= '0;
            btnd_sync_q <= '0;
            btnu_sync_q <= '0;
            btnd_prev_q <= 1'b0;
            btnu_prev_q <= 1'b0;
            op_q        <= OpAdd;
            sel_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            btnd_sync_q <= {btnd_sync_q[SYNC_STAGES-2:0], btnd};
            btnu_sync_q <= {btnu_sync_q[SYNC_STAGES-2:0], btnu};
            btnd_prev_q <= btnd_sync_q[SYNC_STAGES-1];
            btnu_prev_q <= btnu_sync_q[SYNC_STAGES-1];

            case (state_q)
                StIdle: begin
                    // Clear has priority; a simultaneous execute is dropped.
                    if (btnu_pulse) begin
                        bank_q[acc_sel]     <= '0;
                        ovf_flag_q[acc_sel] <= 1'b0;
                    end else if (btnd_pulse) begin
                        op_q    <= op_e'({btnc, btnl, btnr});
                        sel_q   <= acc_sel;
                        a_q     <= bank_q[acc_sel];
                        b_q     <= sw;
                        state_q <= StExec;
                        busy_q  <= 1'b1;
                    end
                end
                StExec: begin
                    res_q   <= alu_res;
                    ovf_q   <= alu_ovf;
                    state_q <= StWrite;
                end
                StWrite: begin
                    bank_q[sel_q]     <= res_q;
                    ovf_flag_q[sel_q] <= ovf_flag_q[sel_q] | ovf_q;
                    state_q           <= StIdle;
                    busy_q            <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign led  = bank_q[acc_sel];
    assign ovf  = ovf_flag_q[acc_sel];
    assign zero = (led == '0);
    assign busy = busy_q;

endmodule

// File: tb/tb_calc_bank.sv
// Self-checking bench for calc_bank with default parameters (WIDTH 16, NACC 4, SYNC_STAGES 2).
module tb_calc_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        btnc, btnl, btnr, btnd, btnu;
    logic [1:0]  acc_sel;
    logic [15:0] sw;
    logic [15:0] led;
    logic        ovf, zero, busy;

    int checks   = 0;
    int failures = 0;

    // Reference state and scoreboard of {sticky ovf, led} expected after each operation
    logic [15:0] m_bank [4];
    logic        m_ovf  [4];
    logic [16:0] sb_q [$];

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND = 3'd2, OR = 3'd3;
    localparam logic [2:0] XOR = 3'd4, SLL = 3'd5, SRA = 3'd6, MUL = 3'd7;

    calc_bank dut (
        .clk     (clk),
        .reset   (reset),
        .btnc    (btnc),
        .btnl    (btnl),
        .btnr    (btnr),
        .btnd    (btnd),
        .btnu    (btnu),
        .acc_sel (acc_sel),
        .sw      (sw),
        .led     (led),
        .ovf     (ovf),
        .zero    (zero),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference op using integer range tests and bit-by-bit shifts; returns {ovf, result}
    function automatic logic [16:0] ref_op(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
        int          sa, sb, r;
        logic [15:0] res;
        logic        o;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        o   = 1'b0;
        res = a;
        r   = 0;
        case (op)
            ADD: begin r = sa + sb; res = r[15:0]; o = (r > 32767) || (r < -32768); end
            SUB: begin r = sa - sb; res = r[15:0]; o = (r > 32767) || (r < -32768); end
            AND: res = a & b;
            OR:  res = a | b;
            XOR: res = a ^ b;
            SLL: for (int i = 0; i < int'(b[3:0]); i++) res = {res[14:0], 1'b0};
            SRA: for (int i = 0; i < int'(b[3:0]); i++) res = {res[15], res[15:1]};
            MUL: begin r = sa * sb; res = r[15:0]; o = (r > 32767) || (r < -32768); end
            default: res = 'x;
        endcase
        return {o, res};
    endfunction

    function automatic logic [16:0] model_apply(input logic [2:0] op, input int sel,
                                                input logic [15:0] b);
        logic [16:0] r;
        r            = ref_op(op, m_bank[sel], b);
        m_bank[sel]  = r[15:0];
        m_ovf[sel]   = m_ovf[sel] | r[16];
        return {m_ovf[sel], m_bank[sel]};
    endfunction

    task automatic pop_compare(input string tag);
        logic [16:0] e;
        check({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, "_led"}, 32'(led), 32'(e[15:0]));
            check({tag, "_ovf"}, 32'(ovf), 32'(e[16]));
            check({tag, "_zero"}, 32'(zero), 32'(e[15:0] == 16'h0));
        end
    endtask

    // One execute press; verifies latency, busy window and operand capture.
    task automatic do_op(input string tag, input logic [2:0] op, input int sel,
                         input logic [15:0] b);
        logic [15:0] old;
        old = m_bank[sel];
        sb_q.push_back(model_apply(op, sel, b));
        {btnc, btnl, btnr} = op;
        acc_sel = 2'(sel);
        sw      = b;
        btnd    = 1'b1;
        @(posedge clk);                       // k: first sample
        @(posedge clk); #1;                   // k+1
        check({tag, "_busy_k1"}, 32'(busy), 32'd0);
        @(posedge clk); #1;                   // k+2: captured
        check({tag, "_busy_k2"}, 32'(busy), 32'd1);
        sw = ~b;
        {btnc, btnl, btnr} = ~op;
        @(posedge clk); #1;                   // k+3
        check({tag, "_led_k3"}, 32'(led), 32'(old));
        @(posedge clk); #1;                   // k+4: written
        pop_compare(tag);
        check({tag, "_busy_k4"}, 32'(busy), 32'd0);
        btnd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_clear(input string tag, input int sel);
        acc_sel = 2'(sel);
        btnu    = 1'b1;
        @(posedge clk);                       // k
        @(posedge clk); #1;                   // k+1
        check({tag, "_pre"}, 32'(led), 32'(m_bank[sel]));
        @(posedge clk); #1;                   // k+2
        check({tag, "_led"}, 32'(led), 32'd0);
        check({tag, "_ovf"}, 32'(ovf), 32'd0);
        m_bank[sel] = '0;
        m_ovf[sel]  = 1'b0;
        btnu = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic show(input string tag, input int sel, input logic [15:0] l,
                        input logic o);
        acc_sel = 2'(sel);
        #1;
        check({tag, "_led"}, 32'(led), 32'(l));
        check({tag, "_ovf"}, 32'(ovf), 32'(o));
    endtask

    initial begin
        int          busy_rises;
        logic        busy_seen;
        logic        busy_prev;

        reset = 1'b1;
        {btnc, btnl, btnr, btnd, btnu} = '0;
        acc_sel = '0;
        sw      = '0;
        for (int i = 0; i < 4; i++) begin m_bank[i] = '0; m_ovf[i] = 1'b0; end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state on every accumulator
        for (int i = 0; i < 4; i++) begin
            acc_sel = 2'(i);
            #1;
            check($sformatf("rst_led%0d", i), 32'(led), 32'h0);
            check($sformatf("rst_zero%0d", i), 32'(zero), 32'd1);
            check($sformatf("rst_ovf%0d", i), 32'(ovf), 32'd0);
            check($sformatf("rst_busy%0d", i), 32'(busy), 32'd0);
        end
        @(posedge clk); #1;

        // Arithmetic chain
        do_op("add5", ADD, 0, 16'd5);
        do_op("sub7", SUB, 0, 16'd7);
        show("chain", 0, 16'hFFFE, 1'b0);
        check("chain_zero", 32'(zero), 32'd0);
        do_clear("clr0", 0);

        // Sticky overflow and multiply
        do_op("add7fff", ADD, 3, 16'h7FFF);
        do_op("add1", ADD, 3, 16'h0001);
        show("ovf_add", 3, 16'h8000, 1'b1);
        do_op("add0", ADD, 3, 16'h0000);
        show("ovf_sticky", 3, 16'h8000, 1'b1);
        do_clear("clr3", 3);
        do_op("load100", ADD, 3, 16'h0100);
        do_op("mul100", MUL, 3, 16'h0100);
        show("mul", 3, 16'h0000, 1'b1);
        check("mul_zero", 32'(zero), 32'd1);
        do_clear("clr3b", 3);

        // Bank independence
        do_op("load3", ADD, 1, 16'd3);
        do_op("load9", ADD, 2, 16'd9);
        do_op("sra1", SRA, 2, 16'd1);
        show("bank2", 2, 16'd4, 1'b0);
        show("bank1", 1, 16'd3, 1'b0);
        show("bank0", 0, 16'd0, 1'b0);
        show("bank3", 3, 16'd0, 1'b0);

        // Held execute button: exactly one increment
        sb_q.push_back(model_apply(ADD, 1, 16'd1));
        {btnc, btnl, btnr} = ADD;
        acc_sel = 2'd1;
        sw      = 16'd1;
        btnd    = 1'b1;
        busy_rises = 0;
        busy_prev  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (busy && !busy_prev) busy_rises++;
            busy_prev = busy;
        end
        check("held_busy_rises", 32'(busy_rises), 32'd1);
        btnd = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        pop_compare("held");
        show("held_val", 1, 16'd4, 1'b0);

        // Second edge inside the busy window is discarded
        sb_q.push_back(model_apply(ADD, 1, 16'd1));
        btnd = 1'b1;
        @(posedge clk); #1;                   // k
        btnd = 1'b0;
        @(posedge clk); #1;                   // k+1
        btnd = 1'b1;
        repeat (3) @(posedge clk);            // k+4
        #1;
        pop_compare("busywin");
        busy_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            busy_seen = busy_seen | busy;
        end
        check("busywin_no_rerun", 32'(busy_seen), 32'd0);
        show("busywin_val", 1, 16'd5, 1'b0);
        btnd = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Clear and execute on the same edge: clear wins, no operation
        acc_sel = 2'd2;
        sw      = 16'd1;
        {btnc, btnl, btnr} = ADD;
        btnu = 1'b1;
        btnd = 1'b1;
        busy_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            busy_seen = busy_seen | busy;
        end
        check("both_busy", 32'(busy_seen), 32'd0);
        check("both_led", 32'(led), 32'd0);
        m_bank[2] = '0;
        m_ovf[2]  = 1'b0;
        btnu = 1'b0;
        btnd = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Remaining ops on accumulator 0, ending in a subtract overflow
        do_op("ld1234", ADD, 0, 16'h1234);
        do_op("and", AND, 0, 16'h0FF0);
        do_op("or", OR, 0, 16'h8001);
        do_op("xor", XOR, 0, 16'hFFFF);
        do_op("sll", SLL, 0, 16'h0004);
        do_op("sra3", SRA, 0, 16'h0013);
        show("sra3_val", 0, 16'hFB9C, 1'b0);
        do_op("subovf", SUB, 0, 16'h7FFF);
        show("subovf_flag", 0, m_bank[0], 1'b1);

        // Reset during EXEC aborts the write
        acc_sel = 2'd1;
        sw      = 16'd10;
        {btnc, btnl, btnr} = ADD;
        btnd = 1'b1;
        @(posedge clk);                       // k
        @(posedge clk);                       // k+1
        @(posedge clk); #1;                   // k+2: EXEC
        check("midrst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        btnd  = 1'b0;
        @(posedge clk); #1;                   // reset edge
        check("midrst_led", 32'(led), 32'd0);
        check("midrst_busy_after", 32'(busy), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin m_bank[i] = '0; m_ovf[i] = 1'b0; end
        busy_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            busy_seen = busy_seen | busy;
        end
        check("midrst_idle", 32'(busy_seen), 32'd0);
        show("midrst_sel1", 1, 16'd0, 1'b0);
        show("midrst_sel0", 0, 16'd0, 1'b0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
